// File: rtl/map_rom_arbiter_if.sv
// Requester-side bundle for the shared map ROM: port A (wall tracer) and
// port B (map overlay) request, grant and read-back signals.
interface map_rom_arbiter_if #(
  parameter int MAP_WBITS = 5,
  parameter int MAP_HBITS = 5
);
  logic                 a_req;
  logic [MAP_WBITS-1:0] a_col;
  logic [MAP_HBITS-1:0] a_row;
  logic                 a_gnt;
  logic [1:0]           a_val;
  logic                 a_valid;

  logic                 b_req;
  logic [MAP_WBITS-1:0] b_col;
  logic [MAP_HBITS-1:0] b_row;
  logic                 b_gnt;
  logic [1:0]           b_val;
  logic                 b_valid;

  // Requesters drive the request side and observe grant/data.
  modport master (
    output a_req, a_col, a_row,
    input  a_gnt, a_val, a_valid,
    output b_req, b_col, b_row,
    input  b_gnt, b_val, b_valid
  );

  // The arbiter observes requests and returns grant/data.
  modport slave (
    input  a_req, a_col, a_row,
    output a_gnt, a_val, a_valid,
    input  b_req, b_col, b_row,
    output b_gnt, b_val, b_valid
  );
endinterface

// File: rtl/map_rom_arbiter.sv
// Two-port arbiter in front of the single map ROM: A has priority, B is
// protected from starvation; responses return a fixed 2 cycles after grant.
module map_rom_arbiter #(
  parameter int MAP_WBITS  = 5,
  parameter int MAP_HBITS  = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  map_rom_arbiter_if.slave     bus,
  output logic [MAP_WBITS-1:0] o_map_col,
  output logic [MAP_HBITS-1:0] o_map_row,
  input  logic [1:0]           i_map_val,
  input  logic                 i_clear,
  output logic [15:0]          o_conflicts
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam int         PORT_A = 0;
  localparam int         PORT_B = 1;

  logic [1:0]           req;
  logic [1:0]           gnt;
  logic [MAP_WBITS-1:0] col [2];
  logic [MAP_HBITS-1:0] row [2];

  logic [MAP_WBITS-1:0] map_col_reg;
  logic [MAP_HBITS-1:0] map_row_reg;
  logic                 owner_reg;
  logic                 pend_reg;
  logic [3:0]           starve_reg;
  logic [15:0]          conflicts_reg;
  logic [1:0]           val_reg   [2];
  logic                 valid_reg [2];

  assign req[PORT_A] = bus.a_req;
  assign req[PORT_B] = bus.b_req;
  assign col[PORT_A] = bus.a_col;
  assign col[PORT_B] = bus.b_col;
  assign row[PORT_A] = bus.a_row;
  assign row[PORT_B] = bus.b_row;

  // B wins when A is idle, or when it has waited out the starvation limit.
  always_comb begin
    gnt         = 2'b00;
    gnt[PORT_B] = req[PORT_B] && (!req[PORT_A] || (starve_reg == STARVE_LIM));
    gnt[PORT_A] = req[PORT_A] && !gnt[PORT_B];
  end

  assign bus.a_gnt = gnt[PORT_A];
  assign bus.b_gnt = gnt[PORT_B];

  // Address capture and owner tracking for the single in-flight stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      map_col_reg <= '0;
      map_row_reg <= '0;
      owner_reg   <= 1'b0;
      pend_reg    <= 1'b0;
    end else begin
      pend_reg <= |gnt;
      if (gnt[PORT_B]) begin
        map_col_reg <= col[PORT_B];
        map_row_reg <= row[PORT_B];
        owner_reg   <= 1'b1;
      end else if (gnt[PORT_A]) begin
        map_col_reg <= col[PORT_A];
        map_row_reg <= row[PORT_A];
        owner_reg   <= 1'b0;
      end
    end
  end

  assign o_map_col = map_col_reg;
  assign o_map_row = map_row_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_reg <= '0;
    end else if (req[PORT_B] && !gnt[PORT_B]) begin
      if (starve_reg != STARVE_LIM) begin
        starve_reg <= starve_reg + 4'd1;
      end
    end else begin
      starve_reg <= '0;
    end
  end

  // Clear beats increment so a vsync during contention reads back as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflicts_reg <= '0;
    end else if (i_clear) begin
      conflicts_reg <= '0;
    end else if (req[PORT_A] && req[PORT_B] && (conflicts_reg != 16'hFFFF)) begin
      conflicts_reg <= conflicts_reg + 16'd1;
    end
  end

  assign o_conflicts = conflicts_reg;

  // Per-port response registers: data holds between responses, valid pulses.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic hit;
      assign hit = pend_reg && (owner_reg == 1'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          val_reg[gi]   <= '0;
          valid_reg[gi] <= 1'b0;
        end else begin
          valid_reg[gi] <= hit;
          if (hit) begin
            val_reg[gi] <= i_map_val;
          end
        end
      end
    end
  endgenerate

  assign bus.a_val   = val_reg[PORT_A];
  assign bus.a_valid = valid_reg[PORT_A];
  assign bus.b_val   = val_reg[PORT_B];
  assign bus.b_valid = valid_reg[PORT_B];

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter with a small ROM table model; every
// expected value below is worked out by hand from the arbitration rules.
module tb_map_rom_arbiter;

  logic        clk;
  logic        reset;
  logic [4:0]  o_map_col;
  logic [4:0]  o_map_row;
  logic [1:0]  i_map_val;
  logic        i_clear;
  logic [15:0] o_conflicts;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] rom_mem [0:31][0:31];

  map_rom_arbiter_if #(.MAP_WBITS(5), .MAP_HBITS(5)) bus ();

  map_rom_arbiter #(.MAP_WBITS(5), .MAP_HBITS(5), .STARVE_MAX(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_map_col   (o_map_col),
    .o_map_row   (o_map_row),
    .i_map_val   (i_map_val),
    .i_clear     (i_clear),
    .o_conflicts (o_conflicts)
  );

  assign i_map_val = rom_mem[o_map_col][o_map_row];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to the next cycle; inputs change here and checks follow #1 later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_col = '0; bus.a_row = '0;
    bus.b_req = 1'b0; bus.b_col = '0; bus.b_row = '0;
    i_clear   = 1'b0;
  endtask

  logic [7:0] exp_b_gnt;
  logic [9:0] exp_a_valid;
  logic [9:0] exp_b_valid;

  initial begin
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 32; r++)
        rom_mem[c][r] = 2'(c ^ r);
    rom_mem[1][1]   = 2'd1;
    rom_mem[2][2]   = 2'd3;
    rom_mem[31][31] = 2'd1;
    // (3,5)=2, (4,4)=0, (5,6)=3 come from the xor fill.

    reset = 1'b0;
    idle_inputs();
    repeat (2) next_cycle();
    #1;
    check("rst_map_col",   32'(o_map_col),   32'd0);
    check("rst_map_row",   32'(o_map_row),   32'd0);
    check("rst_a_valid",   32'(bus.a_valid), 32'd0);
    check("rst_b_valid",   32'(bus.b_valid), 32'd0);
    check("rst_a_val",     32'(bus.a_val),   32'd0);
    check("rst_conflicts", 32'(o_conflicts), 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Single A read at (3,5).
    bus.a_req = 1'b1; bus.a_col = 5'd3; bus.a_row = 5'd5;
    #1;
    check("t1_a_gnt_c0", 32'(bus.a_gnt), 32'd1);
    check("t1_b_gnt_c0", 32'(bus.b_gnt), 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check("t1_col_c1",     32'(o_map_col),   32'd3);
    check("t1_row_c1",     32'(o_map_row),   32'd5);
    check("t1_a_valid_c1", 32'(bus.a_valid), 32'd0);
    next_cycle();
    #1;
    check("t1_a_valid_c2", 32'(bus.a_valid), 32'd1);
    check("t1_a_val_c2",   32'(bus.a_val),   32'd2);
    check("t1_b_valid_c2", 32'(bus.b_valid), 32'd0);
    next_cycle();
    #1;
    check("t1_a_valid_c3", 32'(bus.a_valid), 32'd0);
    check("t1_a_val_c3",   32'(bus.a_val),   32'd2);
    check("t1_col_hold",   32'(o_map_col),   32'd3);

    // Alternating: A at (1,1) then B at (2,2).
    next_cycle();
    bus.a_req = 1'b1; bus.a_col = 5'd1; bus.a_row = 5'd1;
    #1;
    check("t3_a_gnt_c0", 32'(bus.a_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    bus.b_req = 1'b1; bus.b_col = 5'd2; bus.b_row = 5'd2;
    #1;
    check("t3_b_gnt_c1", 32'(bus.b_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("t3_a_valid_c2", 32'(bus.a_valid), 32'd1);
    check("t3_a_val_c2",   32'(bus.a_val),   32'd1);
    check("t3_b_valid_c2", 32'(bus.b_valid), 32'd0);
    next_cycle();
    #1;
    check("t3_b_valid_c3", 32'(bus.b_valid), 32'd1);
    check("t3_b_val_c3",   32'(bus.b_val),   32'd3);
    check("t3_a_valid_c3", 32'(bus.a_valid), 32'd0);
    check("t3_a_val_c3",   32'(bus.a_val),   32'd1);

    // B alone at the far corner.
    next_cycle();
    bus.b_req = 1'b1; bus.b_col = 5'd31; bus.b_row = 5'd31;
    #1;
    check("t6_b_gnt_c0", 32'(bus.b_gnt), 32'd1);
    check("t6_a_gnt_c0", 32'(bus.a_gnt), 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check("t6_col_c1",     32'(o_map_col),   32'd31);
    check("t6_b_valid_c1", 32'(bus.b_valid), 32'd0);
    next_cycle();
    #1;
    check("t6_b_valid_c2", 32'(bus.b_valid), 32'd1);
    check("t6_b_val_c2",   32'(bus.b_val),   32'd1);
    check("t6_conflicts",  32'(o_conflicts), 32'd0);
    next_cycle();

    // Continuous contention for 8 cycles, then 2 drain cycles.
    exp_b_gnt   = 8'b1000_1000;
    exp_a_valid = 10'b01_1101_1100;
    exp_b_valid = 10'b10_0010_0000;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (k < 8) begin
        bus.a_req = 1'b1; bus.a_col = 5'd4; bus.a_row = 5'd4;
        bus.b_req = 1'b1; bus.b_col = 5'd5; bus.b_row = 5'd6;
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 8) begin
        check($sformatf("t2_b_gnt_k%0d", k), 32'(bus.b_gnt), 32'(exp_b_gnt[k]));
        check($sformatf("t2_a_gnt_k%0d", k), 32'(bus.a_gnt), 32'(!exp_b_gnt[k]));
      end
      check($sformatf("t2_a_valid_k%0d", k), 32'(bus.a_valid), 32'(exp_a_valid[k]));
      check($sformatf("t2_b_valid_k%0d", k), 32'(bus.b_valid), 32'(exp_b_valid[k]));
      check($sformatf("t2_conf_k%0d", k), 32'(o_conflicts), 32'((k < 8) ? k : 8));
      if (exp_a_valid[k]) check($sformatf("t2_a_val_k%0d", k), 32'(bus.a_val), 32'd0);
      if (exp_b_valid[k]) check($sformatf("t2_b_val_k%0d", k), 32'(bus.b_val), 32'd3);
    end

    // Saturation: preload near the top, keep contending, then clear.
    next_cycle();
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    force dut.conflicts_reg = 16'hFFFE;
    #1;
    release dut.conflicts_reg;
    check("t5_conf_preload", 32'(o_conflicts), 32'h0000FFFE);
    next_cycle();
    #1;
    check("t5_conf_ffff", 32'(o_conflicts), 32'h0000FFFF);
    next_cycle();
    #1;
    check("t5_conf_sat1", 32'(o_conflicts), 32'h0000FFFF);
    next_cycle();
    i_clear = 1'b1;
    #1;
    check("t5_conf_sat2", 32'(o_conflicts), 32'h0000FFFF);
    next_cycle();
    i_clear = 1'b0;
    #1;
    check("t5_conf_clear", 32'(o_conflicts), 32'd0);
    next_cycle();
    #1;
    check("t5_conf_after", 32'(o_conflicts), 32'd1);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();

    // Reset during an in-flight A read: response must never appear.
    bus.a_req = 1'b1; bus.a_col = 5'd3; bus.a_row = 5'd5;
    #1;
    check("t4_a_gnt_c0", 32'(bus.a_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    #1;
    check("t4_col_rst",   32'(o_map_col),   32'd0);
    check("t4_row_rst",   32'(o_map_row),   32'd0);
    check("t4_a_val_rst", 32'(bus.a_val),   32'd0);
    check("t4_b_val_rst", 32'(bus.b_val),   32'd0);
    check("t4_conf_rst",  32'(o_conflicts), 32'd0);
    next_cycle();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t4_no_a_valid_%0d", k), 32'(bus.a_valid), 32'd0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
